// File: rtl/ddr_line_fetcher_pkg.sv
// Shared definitions for the scanline fetcher: FSM encoding and the Ddr read-request
// field layout used to split a beat address into bank/row/col.
package ddr_line_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RESTART = 2'd3
  } fetch_state_e;

  localparam int DDR_COL_W  = 8;
  localparam int DDR_BANK_W = 3;
  localparam int DDR_ROW_W  = 13;
  localparam int DDR_ADDR_W = DDR_ROW_W + DDR_BANK_W + DDR_COL_W;

  // Row-bank-col ordering keeps a sequential line within one row for 256 beats.
  typedef struct packed {
    logic [DDR_ROW_W-1:0]  row;
    logic [DDR_BANK_W-1:0] bank;
    logic [DDR_COL_W-1:0]  col;
  } ddr_rd_req_t;

  function automatic ddr_rd_req_t split_beat_addr(input logic [DDR_ADDR_W-1:0] beat_addr);
    return ddr_rd_req_t'(beat_addr);
  endfunction

endpackage

// File: rtl/ddr_line_fetcher_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; head is combinational
// from storage and reads as zero while empty.
module ddr_line_fetcher_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (!push_i && pop_i) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ddr_line_fetcher.sv
// Scanline prefetch: issues one Ddr read per pixel pair on line_start, buffers returns
// under a credit limit and hands them out as 16-bit pixels.
module ddr_line_fetcher
  import ddr_line_fetcher_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int FIFO_DEPTH  = 64,
  parameter int ADDR_W      = 24
) (
  input  logic              clk133_p,
  input  logic              rst,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  input  logic              pix_pop,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic              busy,
  output logic              underrun
);

  localparam int LINE_BEATS = LINE_PIXELS / 2;
  localparam int BW = $clog2(LINE_BEATS + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     beats_q;
  logic [CW-1:0]     outst_q, outst_d;
  logic              half_q, underrun_q, req_valid_q;

  logic [CW-1:0] fifo_cnt, cnt_d;
  logic [31:0]   head;
  logic          fifo_empty;
  logic          acc, ret, push, pop_ok, deq, flush, stay_fetch, credit_ok;

  always_comb begin
    acc    = req_valid_q && req_ready;
    ret    = rd_valid && (outst_q != '0);
    push   = ret && (state_q != ST_RESTART);
    pop_ok = pix_pop && !fifo_empty;
    deq    = pop_ok && half_q;
    flush  = (state_q == ST_IDLE && line_start) || (state_q == ST_RESTART && outst_q == '0);

    outst_d = outst_q;
    if (acc && !ret)      outst_d = outst_q + CW'(1);
    else if (!acc && ret) outst_d = outst_q - CW'(1);

    cnt_d = fifo_cnt;
    if (push && !deq)      cnt_d = fifo_cnt + CW'(1);
    else if (!push && deq) cnt_d = fifo_cnt - CW'(1);

    // req_valid is registered, so credit is judged on next-cycle occupancy.
    stay_fetch = (state_q == ST_FETCH) && !line_start && !(acc && beats_q == BW'(1));
    credit_ok  = (SW'(cnt_d) + SW'(outst_d)) < SW'(FIFO_DEPTH);
  end

  ddr_line_fetcher_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk133_p),
    .rst_ni  (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (rd_data),
    .pop_i   (deq),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk133_p) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      outst_q     <= '0;
      half_q      <= 1'b0;
      underrun_q  <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      req_valid_q <= stay_fetch && credit_ok;
      outst_q     <= outst_d;

      if (flush)       half_q <= 1'b0;
      else if (pop_ok) half_q <= ~half_q;

      if (flush)                       underrun_q <= 1'b0;
      else if (pix_pop && fifo_empty)  underrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (line_start) begin
            addr_q  <= line_addr;
            beats_q <= BW'(LINE_BEATS);
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (acc) begin
            addr_q  <= addr_q + ADDR_W'(1);
            beats_q <= beats_q - BW'(1);
          end
          if (line_start) begin
            addr_q  <= line_addr;
            state_q <= ST_RESTART;
          end else if (acc && beats_q == BW'(1)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (line_start) begin
            addr_q  <= line_addr;
            state_q <= ST_RESTART;
          end else if (outst_q == '0) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RESTART: begin
          // Beats still in flight belong to the abandoned line and are dropped.
          if (line_start) addr_q <= line_addr;
          if (outst_q == '0) begin
            beats_q <= BW'(LINE_BEATS);
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign underrun  = underrun_q;
  assign pix_valid = !fifo_empty;
  assign pix_data  = half_q ? head[31:16] : head[15:0];

endmodule

// File: tb/tb_ddr_line_fetcher.sv
// Directed bench for ddr_line_fetcher with a queue-based Ddr responder and pixel scoreboard.
module tb_ddr_line_fetcher;

  logic        clk133_p;
  logic        rst;
  logic        line_start;
  logic [23:0] line_addr;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        pix_pop;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        busy;
  logic        underrun;

  ddr_line_fetcher #(.LINE_PIXELS(640), .FIFO_DEPTH(64), .ADDR_W(24)) dut (
    .clk133_p   (clk133_p),
    .rst        (rst),
    .line_start (line_start),
    .line_addr  (line_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .pix_pop    (pix_pop),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk133_p = 1'b0;
  always #5 clk133_p = ~clk133_p;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_pop = 0;
  int addr_err = 0;
  int pix_err = 0;
  int n0, n1;
  logic [23:0] q[$];
  logic [15:0] exp_pix[$];
  logic [23:0] exp_addr;
  logic auto_ret, pop_en, sb_en, chk_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive returns/pops at the falling edge, log accepts, advance to next falling edge.
  task automatic step();
    logic [23:0] a;
    if (auto_ret) begin
      rd_valid = 1'b0;
      if (q.size() > 0) begin
        a = q.pop_front();
        rd_valid = 1'b1;
        rd_data = {~a[15:0], a[15:0]};
        if (sb_en) begin
          exp_pix.push_back(a[15:0]);
          exp_pix.push_back(~a[15:0]);
        end
      end
    end
    if (rst && req_valid && req_ready) begin
      q.push_back(req_addr);
      n_acc++;
      if (chk_addr) begin
        if (req_addr !== exp_addr) addr_err++;
        exp_addr = exp_addr + 24'd1;
      end
    end
    if (pop_en) pix_pop = pix_valid;
    if (sb_en && pix_pop && pix_valid) begin
      n_pop++;
      if (exp_pix.size() == 0 || pix_data !== exp_pix.pop_front()) pix_err++;
    end
    @(posedge clk133_p);
    @(negedge clk133_p);
  endtask

  initial begin
    rst = 1'b0; line_start = 1'b0; line_addr = '0; req_ready = 1'b0;
    rd_valid = 1'b0; rd_data = '0; pix_pop = 1'b0;
    auto_ret = 1'b0; pop_en = 1'b0; sb_en = 1'b0; chk_addr = 1'b0; exp_addr = '0;
    @(negedge clk133_p);
    step(); step();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_addr",  32'(req_addr),  32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data",  32'(pix_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_underrun",  32'(underrun),  32'd0);
    rst = 1'b1;

    // Full line at 0x000100 with a responsive Ddr and an eager consumer
    line_start = 1'b1; line_addr = 24'h000100; req_ready = 1'b1;
    auto_ret = 1'b1; pop_en = 1'b1; sb_en = 1'b1; chk_addr = 1'b1; exp_addr = 24'h000100;
    step();
    line_start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_req_valid_1edge", 32'(req_valid), 32'd0);
    step();
    check("start_req_valid_2edge", 32'(req_valid), 32'd1);
    check("start_req_addr", 32'(req_addr), 32'h000100);
    for (int i = 0; i < 3000 && busy; i++) step();
    check("line_busy_fell", 32'(busy), 32'd0);
    check("line_accepts", 32'(n_acc), 32'd320);
    check("line_addr_seq_err", 32'(addr_err), 32'd0);
    check("line_last_addr_next", 32'(exp_addr), 32'h000240);
    for (int i = 0; i < 600 && pix_valid; i++) step();
    check("line_pixels_popped", 32'(n_pop), 32'd640);
    check("line_pixel_err", 32'(pix_err), 32'd0);
    check("line_underrun", 32'(underrun), 32'd0);
    pop_en = 1'b0; pix_pop = 1'b0; sb_en = 1'b0; chk_addr = 1'b0; auto_ret = 1'b0;
    req_ready = 1'b0; rd_valid = 1'b0;

    // Pixel ordering within one beat
    line_start = 1'b1; line_addr = 24'h000400;
    step();
    line_start = 1'b0;
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    q.delete();
    rd_valid = 1'b1; rd_data = 32'hBBBBAAAA;
    step();
    rd_valid = 1'b0;
    check("beat_pix_valid", 32'(pix_valid), 32'd1);
    check("beat_even_pixel", 32'(pix_data), 32'h0000AAAA);
    check("beat_next_addr", 32'(req_addr), 32'h000401);
    pix_pop = 1'b1;
    step();
    check("beat_odd_pixel", 32'(pix_data), 32'h0000BBBB);
    check("beat_pix_valid_mid", 32'(pix_valid), 32'd1);
    step();
    pix_pop = 1'b0;
    check("beat_pix_valid_after", 32'(pix_valid), 32'd0);
    check("beat_underrun", 32'(underrun), 32'd0);

    // Credit limit: no consumer, FIFO fills to 64 beats
    n0 = n_acc; req_ready = 1'b1; auto_ret = 1'b1;
    repeat (200) step();
    check("credit_accepts_full", 32'(n_acc - n0), 32'd64);
    check("credit_req_valid_low", 32'(req_valid), 32'd0);
    check("credit_pix_valid", 32'(pix_valid), 32'd1);
    pix_pop = 1'b1;
    step(); step();
    pix_pop = 1'b0;
    repeat (20) step();
    check("credit_one_more", 32'(n_acc - n0), 32'd65);
    check("credit_req_valid_low2", 32'(req_valid), 32'd0);

    // Restart mid-fetch with three beats in flight
    auto_ret = 1'b0; n1 = n_acc;
    pix_pop = 1'b1;
    repeat (6) step();
    pix_pop = 1'b0;
    repeat (5) step();
    check("restart_outstanding", 32'(n_acc - n1), 32'd3);
    line_start = 1'b1; line_addr = 24'h000800;
    step();
    line_start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_req_valid", 32'(req_valid), 32'd0);
    q.delete();
    rd_valid = 1'b1; rd_data = 32'h12345678;
    repeat (3) step();
    rd_valid = 1'b0;
    step();
    check("restart_fifo_empty", 32'(pix_valid), 32'd0);
    step();
    check("restart_req_valid_new", 32'(req_valid), 32'd1);
    check("restart_req_addr_new", 32'(req_addr), 32'h000800);

    // Underrun is sticky until the next line actually starts
    pix_pop = 1'b1;
    step();
    pix_pop = 1'b0;
    step();
    check("underrun_set", 32'(underrun), 32'd1);
    repeat (3) step();
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Address wrap at the top of the beat space
    line_start = 1'b1; line_addr = 24'hFFFFFE;
    step();
    line_start = 1'b0; auto_ret = 1'b1;
    check("wrap_underrun_held", 32'(underrun), 32'd1);
    for (int i = 0; i < 400 && !req_valid; i++) step();
    check("wrap_req_valid", 32'(req_valid), 32'd1);
    check("wrap_addr0", 32'(req_addr), 32'hFFFFFE);
    check("wrap_underrun_clr", 32'(underrun), 32'd0);
    check("wrap_fifo_empty", 32'(pix_valid), 32'd0);
    step();
    check("wrap_addr1", 32'(req_addr), 32'hFFFFFF);
    step();
    check("wrap_addr2", 32'(req_addr), 32'h000000);

    // Reset mid-fetch abandons the line
    rst = 1'b0; auto_ret = 1'b0; rd_valid = 1'b0;
    step();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_valid", 32'(req_valid), 32'd0);
    check("midrst_req_addr", 32'(req_addr), 32'd0);
    check("midrst_pix_valid", 32'(pix_valid), 32'd0);
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_line_fetcher.md
Name: ddr_line_fetcher

Overview:
- Scanline prefetch stage sitting directly upstream of the Ddr controller's read port and downstream of VGA line timing.
- On each line_start it issues LINE_PIXELS/2 sequential single-beat read requests (32 bits = 2 pixels each) to the Ddr controller.
- Returned data is buffered in a credit-limited FIFO and serialised as 16-bit pixels to the scanout logic.
- Runs entirely in the clk133_p domain; any clock-domain crossing toward the 25 MHz pixel domain lives outside this block.

Parameters:
- LINE_PIXELS, 640: pixels per line; must be even. Derived LINE_BEATS = LINE_PIXELS/2.
- FIFO_DEPTH, 64: 32-bit FIFO entries; power of two, ≥ 4.
- ADDR_W, 24: width of the beat (32-bit word) address to the Ddr controller.

Ports:
- clk133_p  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- line_start  in  1  one-cycle pulse requesting the fetch of a new line.
- line_addr  in  ADDR_W  beat address of pixel 0 of the line; sampled when line_start is accepted.
- req_valid  out  1  read request to the Ddr controller is pending.
- req_ready  in  1  Ddr controller accepts the request this cycle.
- req_addr  out  ADDR_W  beat address of the pending request.
- rd_valid  in  1  one 32-bit beat is returned this cycle.
- rd_data  in  32  returned beat; [15:0] = even pixel, [31:16] = odd pixel.
- pix_pop  in  1  consumer takes pix_data this cycle.
- pix_valid  out  1  pix_data holds a valid pixel.
- pix_data  out  16  current pixel.
- busy  out  1  line fetch is in progress (state ≠ IDLE).
- underrun  out  1  sticky: pix_pop arrived while pix_valid was 0. Cleared when a line starts.

Behaviour:
- Reset (rst = 0 at an edge):
  - State IDLE; FIFO empty; half-select = 0.
  - Outstanding counter = 0; beat counter = 0.
  - Outputs: req_valid = 0, req_addr = 0, pix_valid = 0, pix_data = 0, busy = 0, underrun = 0.
  - A reset mid-fetch abandons the line. Beats returned after reset are discarded, because outstanding is 0.
- States: IDLE, FETCH, DRAIN, RESTART.
- IDLE:
  - On line_start: flush the FIFO and half-select, clear underrun, and load addr = line_addr and beats = LINE_BEATS.
  - Enter FETCH on the next cycle.
- FETCH:
  - req_valid = 1 iff (fifo_count + outstanding) < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
  - A request is accepted when req_valid && req_ready. On accept: addr++ (wraps modulo 2^ADDR_W), beats--, outstanding++.
  - When the final beat is accepted, go to DRAIN.
- DRAIN:
  - No requests are issued.
  - When outstanding reaches 0, go to IDLE. FIFO contents remain available for popping.
- Read return:
  - rd_valid with outstanding > 0: push rd_data, outstanding--.
  - rd_valid with outstanding = 0: beat is ignored.
  - Accept and return in the same cycle: outstanding is unchanged.
- Pixel output:
  - pix_valid = FIFO non-empty.
  - pix_data = FIFO head[15:0] when half = 0, head[31:16] when half = 1. Both are combinational from the head register.
  - pix_pop with pix_valid toggles half; when half = 1 it also dequeues.
  - pix_pop without pix_valid: no state change, underrun <= 1.
- line_start during FETCH or DRAIN:
  - Stop issuing requests and go to RESTART. Latch line_addr.
  - RESTART waits for outstanding = 0, discarding returned beats rather than pushing them.
  - Then flush, clear underrun, load the latched address, and enter FETCH.
- line_start during RESTART: replaces the latched address.
- A push and a pop on the same cycle are both honoured; fifo_count is unchanged.
- Latency:
  - From line_start in IDLE, req_valid rises two edges later.
  - rd_valid to pix_valid is 1 cycle (registered FIFO write).

Decomposition:
- Shared package: state encoding (IDLE/FETCH/DRAIN/RESTART) and the Ddr read-request field layout (bank/row/col split of the ADDR_W beat address), shared with Ddr.
- One natural sub-module: sync_fifo (32-bit, FIFO_DEPTH, with count output, synchronous flush input).

Test Plan:
- Reset with rst = 0, then line_start with line_addr = 0x000100 and req_ready tied high → req_addr steps 0x000100 … 0x00023F; exactly 320 accepts; busy falls after the last return.
- rd_data = 0xBBBBAAAA, then pop twice → pix_data = 0xAAAA then 0xBBBB; pix_valid falls after the second pop.
- No pops and immediate returns → req_valid stops with 64 entries buffered. Popping 2 pixels → exactly one new request is issued.
- line_start with line_addr = 0xFFFFFE → requests wrap: 0xFFFFFE, 0xFFFFFF, 0x000000.
- pix_pop while empty → underrun = 1 and stays 1; it clears on the next line_start.
- line_start mid-fetch with 3 reads outstanding → those 3 returns are not pushed; the new line's first req_addr equals the new line_addr; the FIFO is empty at the restart.
